aes_decrypt_mc: RTL

// - Multi-channel AES inverse-cipher engine (FIPS-197 fig.12): one round per clock.
// - Shares one datapath among NUM_CH tagged message streams: InvShiftRows, InvSubBytes, InvAddRoundKey, InvMixColumns.
// - Adds what the single-stream engine lacks: rkey stall, pt_rdy backpressure, abort, optional per-channel CBC.
// - Sits between the round-key scheduler (reverse-order keys) and the plaintext sink.

---
 rtl/aes_decrypt_mc_if.sv | 39 +++
 rtl/aes_decrypt_mc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_mc_if.sv
// Bus bundle for aes_decrypt_mc.
// Groups the ciphertext input, the round-key feed, the plaintext output,
// abort, CBC IV loading and busy. clk/rst are plain ports of the engine.
//   slave  : engine side (aes_decrypt_mc)
//   master : environment side (key scheduler, source, sink)
interface aes_decrypt_mc_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
);
  logic [127:0]    ct;
  logic [CH_W-1:0] ct_ch;
  logic            ct_vld;
  logic            ct_rdy;
  logic [127:0]    rkey;
  logic            rkey_vld;
  logic            next_rkey;
  logic [1:0]      klen_sel;
  logic [127:0]    pt;
  logic [CH_W-1:0] pt_ch;
  logic            pt_vld;
  logic            pt_rdy;
  logic            abort;
  logic [127:0]    iv;
  logic [CH_W-1:0] iv_ch;
  logic            iv_wr;
  logic            busy;

  modport slave (
    input  ct, ct_ch, ct_vld, rkey, rkey_vld, klen_sel, pt_rdy, abort,
           iv, iv_ch, iv_wr,
    output ct_rdy, next_rkey, pt, pt_ch, pt_vld, busy
  );

  modport master (
    output ct, ct_ch, ct_vld, rkey, rkey_vld, klen_sel, pt_rdy, abort,
           iv, iv_ch, iv_wr,
    input  ct_rdy, next_rkey, pt, pt_ch, pt_vld, busy
  );
endinterface

// File: rtl/aes_decrypt_mc.sv
// Multi-channel AES inverse cipher, one round per clock.
// One datapath is shared by NUM_CH tagged streams; a block is accepted in
// IDLE, runs Nr rounds in ROUND (stalling while rkey_vld is low) and is
// presented in HOLD until the sink takes it.
// Round keys arrive last-round-first from an external scheduler; each
// next_rkey pulse consumes the key on the bus.
// Ports: clk, rst (async, active-high), bus (aes_decrypt_mc_if.slave):
//   ct/ct_ch/ct_vld/ct_rdy   ciphertext in, tagged by channel
//   rkey/rkey_vld/next_rkey  round-key feed
//   klen_sel                 key length, sampled at accept (11 blocks accept)
//   pt/pt_ch/pt_vld/pt_rdy   plaintext out
//   abort                    flush of the in-flight block
//   iv/iv_ch/iv_wr           per-channel CBC chain load
//   busy                     high in ROUND or HOLD
// Build option: define AES_DEC_CBC_EN for per-channel CBC chaining;
// without it the engine is ECB only and the iv inputs are ignored.

// One state column: InvSubBytes, AddRoundKey, then optional InvMixColumns.
// The input column has already been through InvShiftRows.
module aes_dec_col (
  input  logic [31:0] col_i,
  input  logic [31:0] key_i,
  input  logic        mix_en_i,
  output logic [31:0] col_o
);
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[(255 - int'(b))*8 +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  logic [3:0][7:0] a, m9, mb, md, me;
  logic [31:0]     sk;

  always_comb begin
    sk = {inv_sbox(col_i[31:24]), inv_sbox(col_i[23:16]),
          inv_sbox(col_i[15:8]),  inv_sbox(col_i[7:0])} ^ key_i;
    // a[3] is row 0 (most significant byte of the column)
    a = sk;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] x2, x4, x8;
      x2 = xt(a[i]);
      x4 = xt(x2);
      x8 = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    if (mix_en_i) begin
      col_o[31:24] = me[3] ^ mb[2] ^ md[1] ^ m9[0];
      col_o[23:16] = m9[3] ^ me[2] ^ mb[1] ^ md[0];
      col_o[15:8]  = md[3] ^ m9[2] ^ me[1] ^ mb[0];
      col_o[7:0]   = mb[3] ^ md[2] ^ m9[1] ^ me[0];
    end else begin
      col_o = sk;
    end
  end
endmodule

module aes_decrypt_mc #(
  parameter int NUM_CH = 4
) (
  input  logic         clk,
  input  logic         rst,
  aes_decrypt_mc_if.slave bus
);
  localparam int CH_W     = $clog2(NUM_CH);
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {IDLE, ROUND, HOLD} fsm_t;

  fsm_t            fsm_q, fsm_d;
  logic [127:0]    st_q, st_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [CH_W-1:0] tag_q, tag_d;

  logic [127:0]    shr;
  logic [127:0]    rnd;
  logic            mix_en;
  logic            accept;

`ifdef AES_DEC_CBC_EN
  logic [127:0]                  ctl_q, ctl_d;
  logic [NUM_CH-1:0][127:0]      chain_q, chain_d;
`else
  logic unused_iv;
  assign unused_iv = ^{bus.iv, bus.iv_ch, bus.iv_wr};
`endif

  function automatic logic [3:0] nr_of(input logic [1:0] k);
    case (k)
      2'b00:   return 4'd10;
      2'b01:   return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  // InvShiftRows: byte r+4c sits at bits [127-8(r+4c) -: 8]; row r is
  // rotated right by r columns.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_shr
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shr[127-8*(r+4*c) -: 8] = st_q[127-8*(r+4*((c-r+4)%4)) -: 8];
    end
  end

  // Last round (counter==1) skips InvMixColumns.
  assign mix_en = (cnt_q != 4'd1);

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    aes_dec_col u_col (
      .col_i    (shr[127-32*c -: 32]),
      .key_i    (bus.rkey[127-32*c -: 32]),
      .mix_en_i (mix_en),
      .col_o    (rnd[127-32*c -: 32])
    );
  end

  always_comb begin
    fsm_d         = fsm_q;
    st_d          = st_q;
    cnt_d         = cnt_q;
    tag_d         = tag_q;
    bus.ct_rdy    = 1'b0;
    bus.next_rkey = 1'b0;
    bus.pt_vld    = 1'b0;
    accept        = 1'b0;
`ifdef AES_DEC_CBC_EN
    ctl_d   = ctl_q;
    chain_d = chain_q;
`endif
    case (fsm_q)
      IDLE: begin
        bus.ct_rdy = bus.rkey_vld & (bus.klen_sel != 2'b11) & ~bus.abort;
        accept     = bus.ct_vld & bus.ct_rdy;
        if (accept) begin
          st_d          = bus.ct ^ bus.rkey;
          tag_d         = bus.ct_ch;
          cnt_d         = nr_of(bus.klen_sel);
          bus.next_rkey = 1'b1;
          fsm_d         = ROUND;
`ifdef AES_DEC_CBC_EN
          ctl_d = bus.ct;
`endif
        end
      end
      ROUND: begin
        if (bus.rkey_vld && !bus.abort) begin
          st_d          = rnd;
          cnt_d         = cnt_q - 4'd1;
          bus.next_rkey = 1'b1;
          if (cnt_q == 4'd1) fsm_d = HOLD;
        end
      end
      HOLD: begin
        // An abort in HOLD withdraws the block so the sink cannot take it.
        bus.pt_vld = ~bus.abort;
        if (bus.pt_rdy && !bus.abort) begin
          fsm_d = IDLE;
`ifdef AES_DEC_CBC_EN
          chain_d[tag_q] = ctl_q;
`endif
        end
      end
      default: fsm_d = IDLE;
    endcase
    if (bus.abort) fsm_d = IDLE;
`ifdef AES_DEC_CBC_EN
    // Written after the handshake update so an IV load on the same channel wins.
    if (bus.iv_wr) chain_d[bus.iv_ch] = bus.iv;
`endif
  end

  always_comb begin
    bus.pt    = '0;
    bus.pt_ch = '0;
    bus.busy  = (fsm_q != IDLE);
    if (fsm_q == HOLD) begin
`ifdef AES_DEC_CBC_EN
      bus.pt = st_q ^ chain_q[tag_q];
`else
      bus.pt = st_q;
`endif
      bus.pt_ch = tag_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= IDLE;
      st_q  <= '0;
      cnt_q <= '0;
      tag_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      st_q  <= st_d;
      cnt_q <= cnt_d;
      tag_q <= tag_d;
    end
  end

`ifdef AES_DEC_CBC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q   <= '0;
      chain_q <= '0;
    end else begin
      ctl_q   <= ctl_d;
      chain_q <= chain_d;
    end
  end
`endif
endmodule
